wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
Two-master Wishbone arbiter that places two bus masters onto the single master port of the system address-decoder switch. The masters are the Zet CPU on port m0 and a DMA/aux master on port m1. The arbiter grants whole bus cycles (CYC-locked), using round-robin or fixed priority. A bus watchdog terminates any strobe that no slave acknowledges, returning 16'hFFFF, so an unmapped or hung slave cannot stall the system.

Parameters:
TIMEOUT, 255, cycles a granted strobe may wait for s_ack_i before watchdog termination (legal 2..65535)
FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins contested arbitration

Ports:
wb_clk_i  in  1  system clock, all state on rising edge
wb_rst_n_i  in  1  synchronous active-low reset
m0_dat_i  in  16  master 0 write data
m0_dat_o  out  16  master 0 read data
m0_adr_i  in  [20:1]  master 0 word address
m0_sel_i  in  2  master 0 byte selects
m0_we_i  in  1  master 0 write enable
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_ack_o  out  1  master 0 acknowledge
m1_dat_i, m1_dat_o, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o  same as m0, for master 1
s_dat_i  in  16  read data from switch
s_dat_o  out  16  write data to switch
s_adr_o  out  [20:1]  address to switch
s_sel_o  out  2  byte selects to switch
s_we_o  out  1  write enable to switch
s_cyc_o  out  1  cycle to switch
s_stb_o  out  1  strobe to switch
s_ack_i  in  1  acknowledge from switch
timeout_o  out  1  one-cycle pulse on watchdog termination

Behaviour:
- States: IDLE, OWN0, OWN1. Registered owner; last-winner pointer lp (reset 1, so m0 wins first contest).
- Reset (wb_rst_n_i=0 at clock edge): state IDLE, lp=1, watchdog count 0, timeout_o 0. Consequently s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o are all 0. Reset mid-transfer abandons the cycle; no ack is issued.
- IDLE: if exactly one mN_cyc_i=1, go to OWNn next cycle. If both are 1: with FIXED_PRIO=1 go to OWN0; otherwise go to the master that is not lp. No requests: stay.
- OWNn: the mux forwards master n's adr/sel/dat/we/cyc to s_*. s_stb_o = mN_cyc_i & mN_stb_i & ~tmo_fire.
- OWNn exit: when mN_cyc_i=0, go to IDLE next cycle and set lp=n. Minimum one IDLE cycle between owners.
- Grant latency: request cycle to first s_stb_o is 1 cycle.
- In IDLE the s_* outputs are 0 (adr/dat/sel/we also 0).
- Ack: mN_ack_o = (state==OWNn) & mN_stb_i & (s_ack_i | tmo_fire). s_ack_i is combinational passthrough.
- Read data: mN_dat_o = s_dat_i when owner and not tmo_fire; 16'hFFFF when tmo_fire; 0 when not owner.
- Non-owner ack and data are always 0. A stray s_ack_i while the owner's stb=0 is ignored.
- Watchdog counter:
  - Width ceil(log2(TIMEOUT+1)).
  - Increments each cycle s_stb_o=1 & s_ack_i=0.
  - Clears on s_ack_i, on stb low, and on state change.
- tmo_fire: combinational when count==TIMEOUT-1 and the strobe is still unacked. The master therefore sees a forced ack on the TIMEOUT-th strobe cycle, and the counter clears.
- timeout_o is the registered tmo_fire (asserted the following cycle, 1 cycle wide).
- If s_ack_i and tmo_fire coincide, the real ack wins: data = s_dat_i, no timeout_o.
- Multi-beat cycles (cyc held, stb toggling) keep ownership. The counter resets between beats.

Test Plan:
- Single access: m0 cyc/stb, adr 20'h00010, s_ack_i on 3rd stb cycle.
  - s_stb_o rises 1 cycle after request.
  - m0_ack_o coincides with s_ack_i; m0_dat_o = s_dat_i (16'hBEEF).
  - Returns to IDLE 1 cycle after cyc drops.
- Contest, round-robin: m0 and m1 request together continuously with 1-cycle slave ack.
  - Grants alternate m0, m1, m0, m1.
  - Each grant is separated by one IDLE cycle.
  - m1_ack_o is never high during OWN0.
- FIXED_PRIO=1: same stimulus -> m0 wins every contest; m1 is granted only when m0_cyc_i drops.
- Locked burst: m1 holds cyc for 4 beats, stb low 1 cycle between beats; m0 requests mid-burst.
  - m0 is not granted until m1_cyc_i=0.
  - s_stb_o = 0 in the gap cycles.
- Watchdog (TIMEOUT=4): m0 strobes an unmapped address, s_ack_i never asserted.
  - m0_ack_o=1 with m0_dat_o=16'hFFFF on the 4th strobe cycle; s_stb_o=0 that cycle.
  - timeout_o pulses the next cycle.
  - Repeat with s_ack_i arriving on that same 4th cycle -> real data, no timeout_o.
- Reset mid-grant: assert wb_rst_n_i=0 during OWN1 with stb pending.
  - Next cycle: state IDLE, s_cyc_o=s_stb_o=0, no acks, timeout_o=0.
  - After release, first contest goes to m0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: CYC-locked two-master Wishbone arbiter with round-robin/fixed priority and a strobe watchdog.
module wb_arbiter2 #(
  parameter int TIMEOUT    = 255,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [20:1] m0_adr_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [20:1] m1_adr_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  input  logic [15:0] s_dat_i,
  output logic [15:0] s_dat_o,
  output logic [20:1] s_adr_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic lp_q, lp_d, tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic own0, own1, stb_raw, tmo_fire;
  assign own0     = state_q == OWN0;
  assign own1     = state_q == OWN1;
  assign stb_raw  = (own0 & m0_cyc_i & m0_stb_i) | (own1 & m1_cyc_i & m1_stb_i);
  assign tmo_fire = stb_raw & ~s_ack_i & (cnt_q == TLAST);
  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    case (state_q)
      IDLE: begin
        // lp names the last winner, so a contest goes to the other master
        if (m0_cyc_i & m1_cyc_i) state_d = (FIXED_PRIO || lp_q) ? OWN0 : OWN1;
        else if (m0_cyc_i)       state_d = OWN0;
        else if (m1_cyc_i)       state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) begin state_d = IDLE; lp_d = 1'b0; end
      OWN1: if (!m1_cyc_i) begin state_d = IDLE; lp_d = 1'b1; end
      default: state_d = IDLE;
    endcase
    cnt_d = (stb_raw & ~s_ack_i & ~tmo_fire & (state_d == state_q)) ? cnt_q + CW'(1) : '0;
    tmo_d = tmo_fire;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      lp_q    <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
  assign s_cyc_o   = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
  assign s_stb_o   = stb_raw & ~tmo_fire;
  assign s_we_o    = own0 ? m0_we_i  : own1 ? m1_we_i  : 1'b0;
  assign s_sel_o   = own0 ? m0_sel_i : own1 ? m1_sel_i : 2'b0;
  assign s_adr_o   = own0 ? m0_adr_i : own1 ? m1_adr_i : 20'b0;
  assign s_dat_o   = own0 ? m0_dat_i : own1 ? m1_dat_i : 16'b0;
  assign m0_ack_o  = own0 & m0_stb_i & (s_ack_i | tmo_fire);
  assign m1_ack_o  = own1 & m1_stb_i & (s_ack_i | tmo_fire);
  assign m0_dat_o  = !own0 ? 16'h0 : tmo_fire ? 16'hFFFF : s_dat_i;
  assign m1_dat_o  = !own1 ? 16'h0 : tmo_fire ? 16'hFFFF : s_dat_i;
  assign timeout_o = tmo_q;
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: random traffic into round-robin and fixed-priority arbiters, checked against a cycle model.
module tb_wb_arbiter2;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]  c, s;
  logic [19:0] adr [2];
  logic [15:0] dat [2];
  logic [1:0]  sel [2];
  logic [1:0]  we;
  logic [15:0] s_dat;
  logic        s_ack;
  logic [15:0] m0_dat_o [2], m1_dat_o [2], s_dat_o [2];
  logic [19:0] s_adr_o [2];
  logic [1:0]  s_sel_o [2];
  logic [1:0]  m0_ack_o, m1_ack_o, s_we_o, s_cyc_o, s_stb_o, timeout_o;
  int n_checks = 0, n_errs = 0;
  int own [2], lp [2], wt [2];
  bit pend [2];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_arbiter2 #(.TIMEOUT(TO), .FIXED_PRIO(k == 1)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .m0_dat_i(dat[0]), .m0_dat_o(m0_dat_o[k]), .m0_adr_i(adr[0]), .m0_sel_i(sel[0]),
      .m0_we_i(we[0]), .m0_cyc_i(c[0]), .m0_stb_i(s[0]), .m0_ack_o(m0_ack_o[k]),
      .m1_dat_i(dat[1]), .m1_dat_o(m1_dat_o[k]), .m1_adr_i(adr[1]), .m1_sel_i(sel[1]),
      .m1_we_i(we[1]), .m1_cyc_i(c[1]), .m1_stb_i(s[1]), .m1_ack_o(m1_ack_o[k]),
      .s_dat_i(s_dat), .s_dat_o(s_dat_o[k]), .s_adr_o(s_adr_o[k]), .s_sel_o(s_sel_o[k]),
      .s_we_o(s_we_o[k]), .s_cyc_o(s_cyc_o[k]), .s_stb_o(s_stb_o[k]), .s_ack_i(s_ack),
      .timeout_o(timeout_o[k])
    );
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  initial begin
    int o, n, ack_pct;
    bit raw, fire, a0, a1;
    logic [63:0] eb;
    rst_n = 1'b0; c = '0; s = '0; we = '0; s_dat = '0; s_ack = 1'b0;
    for (int m = 0; m < 2; m++) begin adr[m] = '0; dat[m] = '0; sel[m] = '0; end
    for (int k = 0; k < 2; k++) begin own[k] = -1; lp[k] = 1; wt[k] = 0; pend[k] = 1'b0; end
    repeat (2) @(posedge clk);
    for (int cy = 0; cy < 3000; cy++) begin
      @(posedge clk);
      #1;
      ack_pct = (cy / 250) % 4 == 0 ? 0 : (cy / 250) % 4 == 1 ? 25 : (cy / 250) % 4 == 2 ? 60 : 100;
      rst_n = $urandom_range(99) >= 2;
      for (int m = 0; m < 2; m++) begin
        c[m]   = c[m] ? ($urandom_range(99) >= 12) : ($urandom_range(99) < 30);
        s[m]   = c[m] && ($urandom_range(99) < 85);
        adr[m] = 20'($urandom);
        dat[m] = 16'($urandom);
        sel[m] = 2'($urandom);
        we[m]  = 1'($urandom);
      end
      s_dat = 16'($urandom);
      s_ack = $urandom_range(99) < ack_pct;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        o    = own[k];
        raw  = (o >= 0) && c[o] && s[o];
        fire = raw && !s_ack && wt[k] == TO - 1;
        eb   = (o < 0) ? 64'd0 : {23'd0, c[o], raw && !fire, we[o], sel[o], adr[o], dat[o]};
        check($sformatf("p%0d_bus", k),
              {23'd0, s_cyc_o[k], s_stb_o[k], s_we_o[k], s_sel_o[k], s_adr_o[k], s_dat_o[k]}, eb);
        a0 = o == 0 && s[0] && (s_ack || fire);
        a1 = o == 1 && s[1] && (s_ack || fire);
        check($sformatf("p%0d_ack_tmo", k), {61'd0, m0_ack_o[k], m1_ack_o[k], timeout_o[k]},
              {61'd0, a0, a1, pend[k]});
        check($sformatf("p%0d_m0_dat", k), 64'(m0_dat_o[k]),
              64'(o == 0 ? (fire ? 16'hFFFF : s_dat) : 16'h0));
        check($sformatf("p%0d_m1_dat", k), 64'(m1_dat_o[k]),
              64'(o == 1 ? (fire ? 16'hFFFF : s_dat) : 16'h0));
        if (!rst_n) begin
          own[k] = -1; lp[k] = 1; wt[k] = 0; pend[k] = 1'b0;
        end else begin
          pend[k] = fire;
          n = o;
          if (o < 0) begin
            if (c[0] && c[1]) n = (k == 1 || lp[k] == 1) ? 0 : 1;
            else if (c[0])    n = 0;
            else if (c[1])    n = 1;
          end else if (!c[o]) begin
            n = -1;
            lp[k] = o;
          end
          wt[k]  = (raw && !s_ack && !fire && n == o) ? wt[k] + 1 : 0;
          own[k] = n;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
